mem_credit_rx: RTL and testbench

MEM_CREDIT_RX -- requirements
Module: mem_credit_rx

---
 rtl/mem_credit_rx_if.sv | 30 +++
 rtl/mem_credit_rx.sv | 85 ++++++++
 tb/tb_mem_credit_rx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_credit_rx_if.sv
// mem_credit_rx_if: memory-network receive bus plus credit return.
// master = sender/controller side, slave = mem_credit_rx.
interface mem_credit_rx_if #(
  parameter int DWIDTH = 64
);
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;
  logic              credit_ret;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  credit_ret
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    input  out_ready,
    output credit_ret
  );
endinterface

// File: rtl/mem_credit_rx.sv
// mem_credit_rx: credit-based receive FIFO for memory network flits.
// Ports: gclk, rstn (async low), bus (in_*, out_*, credit_ret),
// occupancy, overflow_err, parity_err (sticky status).
// Option: MEMCREDIT_PARITY_EN adds one even-parity bit per entry.
module mem_credit_rx #(
  parameter int DEPTH  = 64,
  parameter int DWIDTH = 64
) (
  input  logic                   gclk,
  input  logic                   rstn,
  mem_credit_rx_if.slave         bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow_err,
  output logic                   parity_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [AW:0]       count;
  logic              credit_q;
  logic              ovf_q;
  logic              full;
  logic              deq;
  logic              wr;

  assign full = (count == FULL);
  assign deq  = (count != '0) & bus.out_ready;
  // A dequeue on a full buffer frees the slot the new flit lands in.
  assign wr   = bus.in_valid & (~full | deq);

  assign bus.out_valid  = (count != '0);
  assign bus.out_data   = mem[head];
  assign bus.credit_ret = credit_q;
  assign occupancy      = count;
  assign overflow_err   = ovf_q;

  always_ff @(posedge gclk) begin
    if (wr) mem[tail] <= bus.in_data;
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= deq;
      if (wr)  tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (wr && !deq)
        count <= count + 1'b1;
      else if (deq && !wr)
        count <= count - 1'b1;
      if (bus.in_valid && full && !deq)
        ovf_q <= 1'b1;
    end
  end

`ifdef MEMCREDIT_PARITY_EN
  logic par [DEPTH];
  logic par_q;

  always_ff @(posedge gclk) begin
    if (wr) par[tail] <= ^bus.in_data;
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      par_q <= 1'b0;
    end else if (deq && ((^mem[head]) != par[head])) begin
      par_q <= 1'b1;
    end
  end

  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_credit_rx.sv
// tb_mem_credit_rx: directed vector table plus corner sequences
// for mem_credit_rx (fill/drain, full+write, random, reset, parity).
module tb_mem_credit_rx;
  localparam int DEPTH  = 64;
  localparam int DWIDTH = 64;

  logic       gclk = 1'b0;
  logic       rstn = 1'b0;
  logic [6:0] occupancy;
  logic       overflow_err;
  logic       parity_err;

  mem_credit_rx_if #(.DWIDTH(DWIDTH)) bus ();

  mem_credit_rx #(
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH)
  ) dut (
    .gclk        (gclk),
    .rstn        (rstn),
    .bus         (bus.slave),
    .occupancy   (occupancy),
    .overflow_err(overflow_err),
    .parity_err  (parity_err)
  );

  always #5 gclk = ~gclk;

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d,
                       input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        r;
    logic        eov;
    logic        cd;
    logic [63:0] eod;
    logic        ecr;
    logic [6:0]  eocc;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] q [$];
    logic [63:0] exp_d;
    logic        v;
    logic        r;
    logic [63:0] d;
    logic        dq;
    logic        wr;
    int          cr_seen;
    int          ndeq;
    int          ncr;

    // inputs, then outputs seen before the edge on which inputs land
    tbl[0]  = '{1'b1, 64'h1234, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 7'd0};
    tbl[1]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h1234, 1'b0, 7'd1};
    tbl[2]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 7'd0};
    tbl[3]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 7'd0};
    tbl[4]  = '{1'b1, 64'h1,    1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 7'd0};
    tbl[5]  = '{1'b1, 64'h2,    1'b0, 1'b1, 1'b1, 64'h1,    1'b0, 7'd1};
    tbl[6]  = '{1'b1, 64'h3,    1'b1, 1'b1, 1'b1, 64'h1,    1'b0, 7'd2};
    tbl[7]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h2,    1'b1, 7'd2};
    tbl[8]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h3,    1'b1, 7'd1};
    tbl[9]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 7'd0};
    tbl[10] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 7'd0};

    drive(1'b0, 64'h0, 1'b0);
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_occ", occupancy, 7'd0);
    chk("rst_credit", bus.credit_ret, 1'b0);
    chk("rst_ovf", overflow_err, 1'b0);
    chk("rst_par", parity_err, 1'b0);
    @(posedge gclk);
    @(negedge gclk);
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, tbl[i].eov);
      chk($sformatf("vec%0d_occ", i), occupancy, tbl[i].eocc);
      chk($sformatf("vec%0d_credit", i), bus.credit_ret, tbl[i].ecr);
      if (tbl[i].cd)
        chk($sformatf("vec%0d_data", i), bus.out_data, tbl[i].eod);
      tick();
    end

    // fill to DEPTH with no dequeues
    cr_seen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'(i), 1'b0);
      tick();
      if (bus.credit_ret) cr_seen++;
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("fill_occ", occupancy, 7'd64);
    chk("fill_credits", 64'(cr_seen), 64'd0);
    chk("fill_ovf", overflow_err, 1'b0);

    // drain: in order, one credit pulse per cycle
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 64'h0, 1'b1);
      chk($sformatf("drain%0d_data", i), bus.out_data, 64'(i));
      tick();
      chk($sformatf("drain%0d_credit", i), bus.credit_ret, 1'b1);
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("drain_occ", occupancy, 7'd0);
    tick();
    chk("drain_credit_end", bus.credit_ret, 1'b0);

    // full + write + dequeue, then full + write without dequeue
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'(100 + i), 1'b0);
      tick();
    end
    drive(1'b1, 64'h200, 1'b1);
    chk("fullrw_head", bus.out_data, 64'd100);
    tick();
    chk("fullrw_occ", occupancy, 7'd64);
    chk("fullrw_ovf", overflow_err, 1'b0);
    drive(1'b1, 64'h300, 1'b0);
    tick();
    chk("ovf_set", overflow_err, 1'b1);
    chk("ovf_occ", occupancy, 7'd64);
    for (int i = 0; i < DEPTH; i++) begin
      exp_d = (i < DEPTH - 1) ? 64'(101 + i) : 64'h200;
      drive(1'b0, 64'h0, 1'b1);
      chk($sformatf("wrap%0d_data", i), bus.out_data, exp_d);
      tick();
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("wrap_occ", occupancy, 7'd0);
    chk("ovf_sticky", overflow_err, 1'b1);
    tick();

    // random valid/ready against a queue model
    ndeq = 0;
    ncr  = 0;
    for (int c = 0; c < 200; c++) begin
      v = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0);
      d = {$urandom, $urandom};
      drive(v, d, r);
      chk("rnd_valid", bus.out_valid, 1'(q.size() > 0));
      if (q.size() > 0) chk("rnd_data", bus.out_data, q[0]);
      dq = (q.size() > 0) && r;
      wr = v && ((q.size() < DEPTH) || dq);
      if (dq) begin
        void'(q.pop_front());
        ndeq++;
      end
      if (wr) q.push_back(d);
      tick();
      if (bus.credit_ret) ncr++;
    end
    chk("rnd_occ", occupancy, 7'(q.size()));
    chk("rnd_credits", 64'(ncr), 64'(ndeq));
    for (int k = 0; k < 80 && q.size() > 0; k++) begin
      drive(1'b0, 64'h0, 1'b1);
      chk("rnd_tail_data", bus.out_data, q[0]);
      void'(q.pop_front());
      tick();
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("rnd_empty", occupancy, 7'd0);
    tick();

    // asynchronous reset with 10 flits held
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'(i + 7), 1'b0);
      tick();
    end
    drive(1'b0, 64'h0, 1'b0);
    chk("pre_rst_occ", occupancy, 7'd10);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_occ", occupancy, 7'd0);
    chk("arst_credit", bus.credit_ret, 1'b0);
    chk("arst_ovf", overflow_err, 1'b0);
    chk("arst_par", parity_err, 1'b0);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    chk("inrst_credit", bus.credit_ret, 1'b0);
    @(negedge gclk);
    rstn = 1'b1;
    drive(1'b1, 64'hABCD, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b1);
    chk("post_rst_valid", bus.out_valid, 1'b1);
    chk("post_rst_data", bus.out_data, 64'hABCD);
    chk("post_rst_credit0", bus.credit_ret, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b0);
    chk("post_rst_credit1", bus.credit_ret, 1'b1);
    chk("post_rst_occ", occupancy, 7'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_nocredit", bus.credit_ret, 1'b0);
    end

`ifdef MEMCREDIT_PARITY_EN
    @(negedge gclk);
    rstn = 1'b0;
    @(negedge gclk);
    rstn = 1'b1;
    drive(1'b1, 64'h5, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b0);
    dut.mem[0][0] = ~dut.mem[0][0];
    chk("par_pre", parity_err, 1'b0);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b0);
    chk("par_set", parity_err, 1'b1);
    chk("par_credit", bus.credit_ret, 1'b1);
    tick();
    tick();
    chk("par_sticky", parity_err, 1'b1);
    @(negedge gclk);
    rstn = 1'b0;
    #1;
    chk("par_rst", parity_err, 1'b0);
    @(negedge gclk);
    rstn = 1'b1;
`else
    chk("par_off", parity_err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
